// File: rtl/mux_sel_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mux_seq_pkg
// Brief    : Shared constants, state type and select-order helpers for the
//            16:1 mux bit-serialiser.
// Revision : 1.0  initial release
// ============================================================================
package mux_seq_pkg;

  localparam int N     = 16;  // mux data inputs, fixed by the mux
  localparam int SEL_W = 4;   // log2(N)

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Select index used for the first captured bit of a word.
  function automatic logic [SEL_W-1:0] first_idx(input bit msb_first);
    return msb_first ? SEL_W'(N - 1) : '0;
  endfunction

  // Map the captured-bit count onto the mux select for the chosen order.
  function automatic logic [SEL_W-1:0] sel_of(input logic [SEL_W-1:0] cnt,
                                              input bit               msb_first);
    return msb_first ? (SEL_W'(N - 1) - cnt) : cnt;
  endfunction

  // Advance the captured-bit count; wraps naturally from N-1 back to 0.
  function automatic logic [SEL_W-1:0] step(input logic [SEL_W-1:0] cnt);
    return cnt + SEL_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_sequencer_if
// Brief    : Word-in handshake, mux drive/return and serial-out handshake of
//            the mux bit-serialiser.
// Revision : 1.0  initial release
// ============================================================================
interface mux_sel_sequencer_if;
  import mux_seq_pkg::*;

  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort_i;
  logic [N-1:0]     d_o;
  logic [SEL_W-1:0] sel_o;
  logic             y_i;
  logic             out_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  // Environment side: supplies words, the mux return bit and consumer ready.
  modport master (
    output in_data, in_valid, abort_i, y_i, out_ready,
    input  in_ready, d_o, sel_o, out_bit, out_valid, out_last, busy
  );

  // Sequencer side.
  modport slave (
    input  in_data, in_valid, abort_i, y_i, out_ready,
    output in_ready, d_o, sel_o, out_bit, out_valid, out_last, busy
  );

endinterface
`default_nettype wire

// File: rtl/mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_sequencer
// Brief    : Holds a 16-bit word on a 16:1 mux, steps the select through all
//            positions and streams the returned bits out with valid/ready.
// Revision : 1.0  initial release
// ============================================================================
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_sel_sequencer_if.slave   bus
);

  localparam logic [0:0] c_ST_IDLE  = IDLE;
  localparam logic [0:0] c_ST_SHIFT = SHIFT;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_cnt;
  logic [N-1:0]     r_data;
  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_out_last;

  logic             w_adv;
  logic             w_last_cnt;
  logic             w_in_ready;
  logic             w_accept;

  // A bit can be captured whenever the output register is empty or draining.
  assign w_adv      = (r_state == c_ST_SHIFT) && (!r_out_valid || bus.out_ready);
  assign w_last_cnt = (r_cnt == SEL_W'(N - 1));
  // Ready in IDLE, and on the final capture so the next word joins without a
  // bubble; abort masks acceptance in either case.
  assign w_in_ready = !bus.abort_i &&
                      ((r_state == c_ST_IDLE) || (w_adv && w_last_cnt));
  assign w_accept   = bus.in_valid && w_in_ready;

  // Word capture, select stepping and output register; rst beats abort beats
  // normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (bus.abort_i) begin
      // Word data is retained on the mux; only sequencing and output clear.
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          // The final bit of the previous word may still be waiting here.
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
          if (w_accept) begin
            r_data  <= bus.in_data;
            r_cnt   <= '0;
            r_state <= c_ST_SHIFT;
          end
        end
        default: begin
          if (w_adv) begin
            r_out_bit   <= bus.y_i;
            r_out_valid <= 1'b1;
            r_out_last  <= w_last_cnt;
            r_cnt       <= step(r_cnt);
            if (w_last_cnt) begin
              if (w_accept) begin
                r_data <= bus.in_data;
                r_cnt  <= '0;
              end else begin
                r_state <= c_ST_IDLE;
              end
            end
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.d_o       = r_data;
  assign bus.sel_o     = sel_of(r_cnt, MSB_FIRST);
  assign bus.out_bit   = r_out_bit;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state == c_ST_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_sequencer
// Brief    : Scoreboard bench for the mux bit-serialiser; two instances (LSB
//            and MSB first) share one stimulus, each closed through a 16:1 mux.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_abort;
  logic        s_oready;

  always #5 clk = ~clk;

  mux_sel_sequencer_if if0 ();
  mux_sel_sequencer_if if1 ();

  assign if0.in_data   = s_data;
  assign if0.in_valid  = s_valid;
  assign if0.abort_i   = s_abort;
  assign if0.out_ready = s_oready;
  assign if0.y_i       = if0.d_o[if0.sel_o];
  assign if1.in_data   = s_data;
  assign if1.in_valid  = s_valid;
  assign if1.abort_i   = s_abort;
  assign if1.out_ready = s_oready;
  assign if1.y_i       = if1.d_o[if1.sel_o];

  mux_sel_sequencer #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(if0.slave));
  mux_sel_sequencer #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(if1.slave));

  int         checks = 0;
  int         errors = 0;
  logic [1:0] q0[$];   // {bit, last} expected from the LSB-first instance
  logic [1:0] q1[$];   // {bit, last} expected from the MSB-first instance
  logic [1:0] e0, e1;
  int         hs0 = 0;
  int         cyc = 0;
  int         last_hs_cyc = 0;
  bit         contig = 1'b0;
  int         contig_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a word yields its 16 bits in select order, last flag on the 16th.
  function automatic void push_word(input bit msb, input logic [15:0] w);
    int         idx;
    logic [1:0] e;
    for (int i = 0; i < 16; i++) begin
      idx = msb ? 15 - i : i;
      e   = {w[idx], (i == 15)};
      if (msb) q1.push_back(e);
      else     q0.push_back(e);
    end
  endfunction

  // Monitor: handshakes are decided by values held across the negedge.
  always @(negedge clk) begin
    cyc++;
    if (if0.out_valid === 1'b1 && s_oready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb extra bit: got %0b expected none", if0.out_bit);
      end else begin
        e0 = q0.pop_front();
        chk("lsb out_bit", 32'(if0.out_bit), 32'(e0[1]));
        chk("lsb out_last", 32'(if0.out_last), 32'(e0[0]));
      end
      if (contig) begin
        if (contig_n > 0) chk("b2b gap", 32'(cyc - last_hs_cyc), 32'd1);
        contig_n++;
      end
      last_hs_cyc = cyc;
      hs0++;
    end
    if (if1.out_valid === 1'b1 && s_oready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL msb extra bit: got %0b expected none", if1.out_bit);
      end else begin
        e1 = q1.pop_front();
        chk("msb out_bit", 32'(if1.out_bit), 32'(e1[1]));
        chk("msb out_last", 32'(if1.out_last), 32'(e1[0]));
      end
    end
    if (rst) begin
      q0.delete(); q1.delete();
    end else if (s_abort) begin
      chk("abort in_ready lsb", 32'(if0.in_ready), 32'd0);
      chk("abort in_ready msb", 32'(if1.in_ready), 32'd0);
      q0.delete(); q1.delete();
    end else if (s_valid) begin
      if (if0.in_ready === 1'b1) push_word(1'b0, s_data);
      if (if1.in_ready === 1'b1) push_word(1'b1, s_data);
    end
  end

  task automatic send(input logic [15:0] w);
    int t;
    s_data  = w;
    s_valid = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (if0.in_ready === 1'b1) break;
    end
    if (t == 200) begin
      checks++; errors++;
      $display("FAIL accept timeout: got in_ready=0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 400; t++) begin
      if (q0.size() == 0 && q1.size() == 0 && !if0.busy && !if0.out_valid) break;
      @(posedge clk); #1;
    end
    if (t == 400) begin
      checks++; errors++;
      $display("FAIL drain timeout: got %0d pending expected 0", q0.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int n);
    int t;
    for (t = 0; t < 200 && hs0 < n; t++) @(posedge clk);
    if (hs0 < n) begin
      checks++; errors++;
      $display("FAIL handshake timeout: got %0d expected %0d", hs0, n);
    end
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " out_valid"}, 32'(if0.out_valid), 32'd0);
    chk({tag, " out_bit"},   32'(if0.out_bit),   32'd0);
    chk({tag, " out_last"},  32'(if0.out_last),  32'd0);
    chk({tag, " busy"},      32'(if0.busy),      32'd0);
    chk({tag, " d_o"},       32'(if0.d_o),       32'd0);
    chk({tag, " sel lsb"},   32'(if0.sel_o),     32'd0);
    chk({tag, " sel msb"},   32'(if1.sel_o),     32'd15);
    chk({tag, " msb valid"}, 32'(if1.out_valid), 32'd0);
  endtask

  // Select stepping and first-bit latency after a word is accepted.
  task automatic chk_sweep(input logic [15:0] w);
    send(w);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("sweep sel lsb", 32'(if0.sel_o), 32'(k));
      chk("sweep sel msb", 32'(if1.sel_o), 32'(15 - k));
      chk("sweep d_o", 32'(if0.d_o), 32'(w));
      if (k == 0) chk("first cycle out_valid", 32'(if0.out_valid), 32'd0);
      if (k == 1) chk("latency out_valid", 32'(if0.out_valid), 32'd1);
    end
    wait_drain();
  endtask

  initial begin
    int base;
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h1234; s_abort = 1'b0; s_oready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(if0.in_ready), 32'd1);
    chk("post-reset busy", 32'(if0.busy), 32'd0);
    @(posedge clk); #1;

    chk_sweep(16'hA5C3);
    chk_sweep(16'h8001);

    // Back-to-back words with no idle cycle between them.
    contig = 1'b1; contig_n = 0;
    send(16'hFFFF);
    send(16'h0000);
    wait_drain();
    contig = 1'b0;
    chk("b2b bit count", 32'(contig_n), 32'd32);

    // Backpressure after the third bit.
    base = hs0;
    send(16'h00F0);
    wait_hs(base + 3);
    s_oready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp out_valid", 32'(if0.out_valid), 32'd1);
      chk("bp sel lsb", 32'(if0.sel_o), 32'd4);
      chk("bp sel msb", 32'(if1.sel_o), 32'd11);
      chk("bp d_o", 32'(if0.d_o), 32'h00F0);
    end
    @(posedge clk); #1;
    s_oready = 1'b1;
    wait_drain();

    // Abort mid-word with a competing word offered.
    base = hs0;
    send(16'h3C5A);
    wait_hs(base + 7);
    s_abort = 1'b1; s_valid = 1'b1; s_data = 16'hFFFF;
    @(posedge clk); #1;
    s_abort = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("abort out_valid", 32'(if0.out_valid), 32'd0);
    chk("abort busy", 32'(if0.busy), 32'd0);
    chk("abort d_o kept", 32'(if0.d_o), 32'h3C5A);
    @(posedge clk); #1;
    send(16'h1234);
    wait_drain();

    // Reset mid-word.
    base = hs0;
    send(16'h5A5A);
    wait_hs(base + 7);
    rst = 1'b1; s_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk_reset_vals("mid reset");
    chk("mid reset in_ready", 32'(if0.in_ready), 32'd1);
    @(posedge clk); #1;
    send(16'hC0DE);
    wait_drain();

    // Random traffic with backpressure and occasional aborts.
    repeat (600) begin
      @(posedge clk); #1;
      s_oready = ($urandom_range(3) != 0);
      s_valid  = $urandom_range(1) == 1;
      s_data   = 16'($urandom);
      s_abort  = ($urandom_range(39) == 0);
    end
    s_valid = 1'b0; s_abort = 1'b0; s_oready = 1'b1;
    wait_drain();
    chk("final queue lsb", 32'(q0.size()), 32'd0);
    chk("final queue msb", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
